id_ex_stage: RTL

- ID/EX pipeline register plus execute-side operand forwarding. It sits directly upstream of the ALU.
- It captures decoded operands and control from the Decode stage each cycle.
- It resolves RAW hazards from the Memory and Writeback stages, then drives SrcAE, SrcBE and ALUControlE into the ALU.
- It also forwards WriteDataE, RdE and the memory/writeback control bits down the pipe.

---
 rtl/riscv_pkg.sv | 26 ++
 rtl/forward_unit.sv | 38 +++
 rtl/id_ex_stage.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared types and widths for the ID/EX stage and its forwarding logic.
// Contents: XLEN / REG_AW widths, ALU operation codes, forward-select enum,
// writeback-source type.
package riscv_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  // ALU operation code carried from Decode to the ALU
  typedef logic [2:0] alu_ctrl_t;
  localparam alu_ctrl_t ALU_ADD = 3'b000;
  localparam alu_ctrl_t ALU_SUB = 3'b001;
  localparam alu_ctrl_t ALU_AND = 3'b010;
  localparam alu_ctrl_t ALU_OR  = 3'b011;

  // Operand source: register-file copy, Writeback result, or Memory ALU result
  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  // Writeback source select
  typedef logic [1:0] result_src_t;

endpackage

// File: rtl/forward_unit.sv
// Execute-stage RAW forwarding select. Pure combinational.
// Inputs : Rs1E, Rs2E (E-stage sources), RdM/RegWriteM, RdW/RegWriteW.
// Outputs: FwdAE, FwdBE (fwd_sel_t). Memory beats Writeback; x0 never forwards.
module forward_unit #(
  parameter int unsigned REG_AW = riscv_pkg::REG_AW
) (
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RdM,
  input  logic              RegWriteM,
  input  logic [REG_AW-1:0] RdW,
  input  logic              RegWriteW,
  output riscv_pkg::fwd_sel_t FwdAE,
  output riscv_pkg::fwd_sel_t FwdBE
);
  import riscv_pkg::*;

  // Operand A select, newest producer first
  always_comb begin
    FwdAE = FWD_RF;
    if (RegWriteM && (RdM != '0) && (RdM == Rs1E)) begin
      FwdAE = FWD_M;
    end else if (RegWriteW && (RdW != '0) && (RdW == Rs1E)) begin
      FwdAE = FWD_W;
    end
  end

  // Operand B select, same rule on Rs2E
  always_comb begin
    FwdBE = FWD_RF;
    if (RegWriteM && (RdM != '0) && (RdM == Rs2E)) begin
      FwdBE = FWD_M;
    end else if (RegWriteW && (RdW != '0) && (RdW == Rs2E)) begin
      FwdBE = FWD_W;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with execute-side operand forwarding into the ALU.
// Inputs : clk, reset (async, active-high), StallE, FlushE, Decode operands
//          and control (*D), Memory/Writeback forward sources (*M, *W).
// Outputs: SrcAE/SrcBE/ALUControlE to the ALU, WriteDataE for stores, and
//          registered PC/immediate/addresses/control (*E) for later stages.
// Macro  : ID_EX_FORWARD_EN enables M/W forwarding; when undefined the
//          operands always come from the registered register-file data.
module id_ex_stage #(
  parameter int unsigned N      = riscv_pkg::XLEN,
  parameter int unsigned REG_AW = riscv_pkg::REG_AW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              StallE,
  input  logic              FlushE,
  input  logic [N-1:0]      RD1D,
  input  logic [N-1:0]      RD2D,
  input  logic [N-1:0]      ImmExtD,
  input  logic [N-1:0]      PCD,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] RdD,
  input  logic              RegWriteD,
  input  logic              MemWriteD,
  input  logic              ALUSrcD,
  input  logic              ValidD,
  input  logic [1:0]        ResultSrcD,
  input  logic [2:0]        ALUControlD,
  input  logic [N-1:0]      ALUResultM,
  input  logic [REG_AW-1:0] RdM,
  input  logic              RegWriteM,
  input  logic [N-1:0]      ResultW,
  input  logic [REG_AW-1:0] RdW,
  input  logic              RegWriteW,
  output logic [N-1:0]      SrcAE,
  output logic [N-1:0]      SrcBE,
  output logic [2:0]        ALUControlE,
  output logic [N-1:0]      WriteDataE,
  output logic [N-1:0]      PCE,
  output logic [N-1:0]      ImmExtE,
  output logic [REG_AW-1:0] Rs1E,
  output logic [REG_AW-1:0] Rs2E,
  output logic [REG_AW-1:0] RdE,
  output logic              RegWriteE,
  output logic              MemWriteE,
  output logic              ValidE,
  output logic [1:0]        ResultSrcE
);
  import riscv_pkg::*;

  logic [N-1:0]      rd1_q, rd1_d, rd2_q, rd2_d;
  logic [N-1:0]      imm_q, imm_d, pc_q, pc_d;
  logic [REG_AW-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic              regwrite_q, regwrite_d, memwrite_q, memwrite_d;
  logic              alusrc_q, alusrc_d, valid_q, valid_d;
  result_src_t       resultsrc_q, resultsrc_d;
  alu_ctrl_t         aluctrl_q, aluctrl_d;

  fwd_sel_t fwd_a_c, fwd_b_c;
  logic [N-1:0] fwd_a_val_c, fwd_b_val_c;

  // Next-state: flush beats stall beats capture
  always_comb begin
    rd1_d       = rd1_q;
    rd2_d       = rd2_q;
    imm_d       = imm_q;
    pc_d        = pc_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    rd_d        = rd_q;
    regwrite_d  = regwrite_q;
    memwrite_d  = memwrite_q;
    alusrc_d    = alusrc_q;
    valid_d     = valid_q;
    resultsrc_d = resultsrc_q;
    aluctrl_d   = aluctrl_q;
    if (FlushE) begin
      rd1_d       = '0;
      rd2_d       = '0;
      imm_d       = '0;
      pc_d        = '0;
      rs1_d       = '0;
      rs2_d       = '0;
      rd_d        = '0;
      regwrite_d  = 1'b0;
      memwrite_d  = 1'b0;
      alusrc_d    = 1'b0;
      valid_d     = 1'b0;
      resultsrc_d = '0;
      aluctrl_d   = ALU_ADD;
    end else if (!StallE) begin
      rd1_d       = RD1D;
      rd2_d       = RD2D;
      imm_d       = ImmExtD;
      pc_d        = PCD;
      rs1_d       = Rs1D;
      rs2_d       = Rs2D;
      rd_d        = RdD;
      regwrite_d  = RegWriteD;
      memwrite_d  = MemWriteD;
      alusrc_d    = ALUSrcD;
      valid_d     = ValidD;
      resultsrc_d = ResultSrcD;
      aluctrl_d   = ALUControlD;
    end
  end

  // E-stage registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd1_q       <= '0;
      rd2_q       <= '0;
      imm_q       <= '0;
      pc_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      regwrite_q  <= 1'b0;
      memwrite_q  <= 1'b0;
      alusrc_q    <= 1'b0;
      valid_q     <= 1'b0;
      resultsrc_q <= '0;
      aluctrl_q   <= ALU_ADD;
    end else begin
      rd1_q       <= rd1_d;
      rd2_q       <= rd2_d;
      imm_q       <= imm_d;
      pc_q        <= pc_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rd_q        <= rd_d;
      regwrite_q  <= regwrite_d;
      memwrite_q  <= memwrite_d;
      alusrc_q    <= alusrc_d;
      valid_q     <= valid_d;
      resultsrc_q <= resultsrc_d;
      aluctrl_q   <= aluctrl_d;
    end
  end

`ifdef ID_EX_FORWARD_EN
  forward_unit #(.REG_AW(REG_AW)) u_forward_unit (
    .Rs1E      (rs1_q),
    .Rs2E      (rs2_q),
    .RdM       (RdM),
    .RegWriteM (RegWriteM),
    .RdW       (RdW),
    .RegWriteW (RegWriteW),
    .FwdAE     (fwd_a_c),
    .FwdBE     (fwd_b_c)
  );
`else
  // Hazard unit stalls on every RAW hazard, so operands come from the RF copy
  assign fwd_a_c = FWD_RF;
  assign fwd_b_c = FWD_RF;
  logic unused_fwd_c;
  assign unused_fwd_c = ^{RdM, RegWriteM, RdW, RegWriteW};
`endif

  // Operand muxes, re-evaluated every cycle including stalls
  always_comb begin
    case (fwd_a_c)
      FWD_M:   fwd_a_val_c = ALUResultM;
      FWD_W:   fwd_a_val_c = ResultW;
      default: fwd_a_val_c = rd1_q;
    endcase
    case (fwd_b_c)
      FWD_M:   fwd_b_val_c = ALUResultM;
      FWD_W:   fwd_b_val_c = ResultW;
      default: fwd_b_val_c = rd2_q;
    endcase
  end

  assign SrcAE       = fwd_a_val_c;
  assign WriteDataE  = fwd_b_val_c;
  assign SrcBE       = alusrc_q ? imm_q : fwd_b_val_c;
  assign ALUControlE = aluctrl_q;
  assign PCE         = pc_q;
  assign ImmExtE     = imm_q;
  assign Rs1E        = rs1_q;
  assign Rs2E        = rs2_q;
  assign RdE         = rd_q;
  assign RegWriteE   = regwrite_q;
  assign MemWriteE   = memwrite_q;
  assign ValidE      = valid_q;
  assign ResultSrcE  = resultsrc_q;

endmodule
